mux_sel_sequencer: RTL and testbench



---
 rtl/mux_sel_sequencer.sv | 155 +++++++++++++++
 tb/tb_mux_sel_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: drives an external 8:1 bit mux with a latched word and a
// stepped select, samples the mux output once per bit period, emits it as a
// serial bit with a valid strobe and reassembles the bits into word_out.
module mux_sel_sequencer #(
    parameter int unsigned DIV_WIDTH = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           data_in,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [7:0]           a,
    output logic [2:0]           sel,
    input  logic                 mux_out,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           word_out
);

    localparam logic [2:0] FIRST_SEL = MSB_FIRST ? 3'd7 : 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_a;
    logic [2:0]             r_sel;
    logic [DIV_WIDTH-1:0]   r_div;
    logic [DIV_WIDTH-1:0]   r_cnt;
    logic [2:0]             r_bitn;
    logic [7:0]             r_capture;
    logic                   r_bit_out;
    logic                   r_bit_valid;
    logic [7:0]             r_word_out;

    state_t                 w_state_next;
    logic [7:0]             w_a_next;
    logic [2:0]             w_sel_next;
    logic [DIV_WIDTH-1:0]   w_div_next;
    logic [DIV_WIDTH-1:0]   w_cnt_next;
    logic [2:0]             w_bitn_next;
    logic [7:0]             w_capture_next;
    logic                   w_bit_out_next;
    logic                   w_bit_valid_next;
    logic [7:0]             w_word_out_next;

    logic                   w_sample;
    logic [2:0]             w_step_sel;
    logic [7:0]             w_capture_merged;

    // Bit period ends when the counter reaches the latched divider; the
    // compare happens before any increment so div all-ones cannot overflow.
    assign w_sample   = (r_cnt == r_div);
    assign w_step_sel = MSB_FIRST ? (r_sel - 3'd1) : (r_sel + 3'd1);

    // Capture register with the bit currently on the mux merged in, so the
    // final sample lands in word_out on the same edge it is taken.
    always_comb begin
        w_capture_merged        = r_capture;
        w_capture_merged[r_sel] = mux_out;
    end

    // Next-state and datapath next values; everything holds unless updated.
    always_comb begin
        w_state_next     = r_state;
        w_a_next         = r_a;
        w_sel_next       = r_sel;
        w_div_next       = r_div;
        w_cnt_next       = r_cnt;
        w_bitn_next      = r_bitn;
        w_capture_next   = r_capture;
        w_bit_out_next   = r_bit_out;
        w_bit_valid_next = 1'b0;
        w_word_out_next  = r_word_out;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next   = ST_RUN;
                    w_a_next       = data_in;
                    w_div_next     = div;
                    w_sel_next     = FIRST_SEL;
                    w_cnt_next     = '0;
                    w_bitn_next    = '0;
                    w_capture_next = '0;
                end
            end
            ST_RUN: begin
                if (w_sample) begin
                    w_bit_out_next   = mux_out;
                    w_bit_valid_next = 1'b1;
                    w_capture_next   = w_capture_merged;
                    w_cnt_next       = '0;
                    // Stepping past the last index wraps back to FIRST_SEL.
                    w_sel_next       = w_step_sel;
                    w_bitn_next      = r_bitn + 3'd1;
                    if (r_bitn == 3'd7) begin
                        w_word_out_next = w_capture_merged;
                        w_state_next    = ST_DONE;
                    end
                end else begin
                    w_cnt_next = r_cnt + DIV_WIDTH'(1);
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any scan immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_sel       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_bitn      <= '0;
            r_capture   <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_word_out  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_a         <= w_a_next;
            r_sel       <= w_sel_next;
            r_div       <= w_div_next;
            r_cnt       <= w_cnt_next;
            r_bitn      <= w_bitn_next;
            r_capture   <= w_capture_next;
            r_bit_out   <= w_bit_out_next;
            r_bit_valid <= w_bit_valid_next;
            r_word_out  <= w_word_out_next;
        end
    end

    assign a         = r_a;
    assign sel       = r_sel;
    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign word_out  = r_word_out;
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: one LSB-first and one MSB-first instance, each
// looped back through a behavioural 8:1 mux. Expected bits/words are queued
// when a scan is started and popped as bit_valid/done appear.
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic [7:0] div0 = '0, div1 = '0;
    logic [7:0] a0, a1, wo0, wo1;
    logic [2:0] sel0, sel1;
    logic       mo0, mo1, bo0, bo1, bv0, bv1, busy0, busy1, done0, done1;

    int n_total = 0;
    int n_pass  = 0;

    bit         q_bit[$];
    logic [7:0] q_word[$];

    always #5 clk = ~clk;

    // Behavioural mux closing the loop.
    assign mo0 = a0[sel0];
    assign mo1 = a1[sel1];

    mux_sel_sequencer #(.DIV_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .start(start0), .data_in(data0), .div(div0),
        .a(a0), .sel(sel0), .mux_out(mo0), .bit_out(bo0), .bit_valid(bv0),
        .busy(busy0), .done(done0), .word_out(wo0)
    );

    mux_sel_sequencer #(.DIV_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .start(start1), .data_in(data1), .div(div1),
        .a(a1), .sel(sel1), .mux_out(mo1), .bit_out(bo1), .bit_valid(bv1),
        .busy(busy1), .done(done1), .word_out(wo1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start a scan on instance inst and follow it to done. Cycle 1 is the one
    // right after the accepting edge; bit k is expected in cycle (k+1)*per+1
    // and done in cycle 8*per+1. poke_bit >= 0 pulses start with 8'hFF for
    // one edge when that bit is seen. keep leaves start asserted on return.
    task automatic run_scan(input bit inst, input logic [7:0] data, input int dv,
                            input int poke_bit, input bit keep);
        int         per;
        int         cyc;
        int         nbits;
        int         idx;
        bit         seen_done;
        bit         poke_on;
        bit         eb;
        logic [7:0] dd;
        logic [7:0] ew;
        logic [7:0] ca, cwo;
        logic [2:0] csel, esel;
        logic       cbv, cbo, cbusy, cdone;
        logic [7:0] dvb;

        per       = dv + 1;
        nbits     = 0;
        seen_done = 1'b0;
        poke_on   = 1'b0;
        dd        = data;
        dvb       = dv[7:0];
        if (inst) begin start1 = 1'b1; data1 = data; div1 = dvb; end
        else      begin start0 = 1'b1; data0 = data; div0 = dvb; end
        for (int k = 0; k < 8; k++) q_bit.push_back(dd[inst ? 7 - k : k]);
        q_word.push_back(data);
        tick();
        cyc = 1;
        if (!keep) begin
            if (inst) start1 = 1'b0; else start0 = 1'b0;
        end

        while (cyc <= 8 * per + 2 && !seen_done) begin
            if (poke_on) begin
                poke_on = 1'b0;
                if (inst) begin start1 = 1'b0; data1 = data; end
                else      begin start0 = 1'b0; data0 = data; end
            end
            ca    = inst ? a1 : a0;
            csel  = inst ? sel1 : sel0;
            cbv   = inst ? bv1 : bv0;
            cbo   = inst ? bo1 : bo0;
            cbusy = inst ? busy1 : busy0;
            cdone = inst ? done1 : done0;
            cwo   = inst ? wo1 : wo0;

            if (cyc <= 8 * per) begin
                idx  = (cyc - 1) / per;
                esel = inst ? 3'(7 - idx) : 3'(idx);
                n_total++;
                if (cbusy !== 1'b1) $display("FAIL busy_run cyc=%0d got %b exp 1", cyc, cbusy);
                else n_pass++;
                n_total++;
                if (csel !== esel) $display("FAIL sel cyc=%0d got %0d exp %0d", cyc, csel, esel);
                else n_pass++;
                n_total++;
                if (ca !== data) $display("FAIL a_stable cyc=%0d got %h exp %h", cyc, ca, data);
                else n_pass++;
            end

            if (cbv === 1'b1) begin
                n_total++;
                if (q_bit.size() == 0) begin
                    $display("FAIL extra_bit cyc=%0d got bit_valid with no bit expected", cyc);
                end else begin
                    eb = q_bit.pop_front();
                    if (cbo !== eb) $display("FAIL bit_out k=%0d got %b exp %b", nbits, cbo, eb);
                    else n_pass++;
                end
                n_total++;
                if (cyc != (nbits + 1) * per + 1)
                    $display("FAIL bit_time k=%0d got cyc %0d exp %0d", nbits, cyc, (nbits + 1) * per + 1);
                else n_pass++;
                if (nbits == poke_bit) begin
                    poke_on = 1'b1;
                    if (inst) begin start1 = 1'b1; data1 = 8'hFF; end
                    else      begin start0 = 1'b1; data0 = 8'hFF; end
                end
                nbits++;
            end

            if (cdone === 1'b1) begin
                seen_done = 1'b1;
                n_total++;
                if (cyc != 8 * per + 1) $display("FAIL done_time got cyc %0d exp %0d", cyc, 8 * per + 1);
                else n_pass++;
                n_total++;
                if (cbusy !== 1'b0) $display("FAIL busy_done got %b exp 0", cbusy);
                else n_pass++;
                n_total++;
                if (nbits != 8) $display("FAIL bit_count got %0d exp 8", nbits);
                else n_pass++;
                ew = q_word.pop_front();
                n_total++;
                if (cwo !== ew) $display("FAIL word_out got %h exp %h", cwo, ew);
                else n_pass++;
            end

            if (!seen_done) begin
                tick();
                cyc++;
            end
        end

        if (!seen_done) begin
            n_total++;
            $display("FAIL done_timeout got no done within %0d cycles exp done at %0d", 8 * per + 2, 8 * per + 1);
            q_bit.delete();
            q_word.delete();
        end

        if (!keep) begin
            for (int i = 0; i < 2; i++) begin
                tick();
                n_total++;
                if ((inst ? done1 : done0) !== 1'b0) $display("FAIL done_once i=%0d got 1 exp 0", i);
                else n_pass++;
                n_total++;
                if ((inst ? busy1 : busy0) !== 1'b0) $display("FAIL idle_after i=%0d got busy 1 exp 0", i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b0;
        start0 = 1'b1; data0 = 8'hA5; div0 = 8'd1;
        tick();
        start0 = 1'b0;
        tick(); tick(); tick();
        // Mid-cycle, no clock edge between assertion and sampling.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (a0 !== 8'h00) $display("FAIL rst_a got %h exp 00", a0); else n_pass++;
        n_total++;
        if (sel0 !== 3'd0) $display("FAIL rst_sel got %0d exp 0", sel0); else n_pass++;
        n_total++;
        if (busy0 !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy0); else n_pass++;
        n_total++;
        if ({bo0, bv0, done0} !== 3'b000) $display("FAIL rst_bits got %b exp 000", {bo0, bv0, done0}); else n_pass++;
        n_total++;
        if (wo0 !== 8'h00) $display("FAIL rst_word got %h exp 00", wo0); else n_pass++;
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_total++;
            if ({busy0, done0, bv0, busy1, done1, bv1} !== 6'b0)
                $display("FAIL idle_quiet i=%0d got %b exp 000000", i, {busy0, done0, bv0, busy1, done1, bv1});
            else n_pass++;
        end
    endtask

    task automatic test_lsb_div0;
        run_scan(1'b0, 8'hA5, 0, -1, 1'b0);
    endtask

    task automatic test_msb_div2;
        run_scan(1'b1, 8'h3C, 2, -1, 1'b0);
    endtask

    task automatic test_ignore_start;
        run_scan(1'b0, 8'hA5, 0, 3, 1'b0);
    endtask

    task automatic test_reset_mid;
        int nb;
        nb = 0;
        start0 = 1'b1; data0 = 8'h5A; div0 = 8'd1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 40 && nb < 5; i++) begin
            if (bv0 === 1'b1) nb++;
            if (nb < 5) tick();
        end
        n_total++;
        if (nb != 5) $display("FAIL mid_bits got %0d exp 5", nb); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if (busy0 !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy0); else n_pass++;
        n_total++;
        if (wo0 !== 8'h00) $display("FAIL mid_word got %h exp 00", wo0); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_total++;
            if (done0 !== 1'b0 || bv0 !== 1'b0) $display("FAIL mid_nodone i=%0d got done %b valid %b exp 0 0", i, done0, bv0);
            else n_pass++;
        end
        run_scan(1'b0, 8'h81, 1, -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_scan(1'b0, 8'hF0, 0, -1, 1'b1);
        data0 = 8'h0F;
        tick();
        n_total++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) $display("FAIL b2b_idle got busy %b done %b exp 0 0", busy0, done0);
        else n_pass++;
        run_scan(1'b0, 8'h0F, 0, -1, 1'b0);
    endtask

    task automatic test_div_max;
        run_scan(1'b0, 8'h96, 255, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_lsb_div0();
        test_msb_div2();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_div_max();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish exp finish before 1000000");
        $fatal(1);
    end

endmodule
